scan_chain_loader: RTL and testbench
====================================

Name: scan_chain_loader

Overview:
- Host-side driver for the memory-bank scan chain: owns scan_enable/scan_in and consumes scan_out.
- Takes a byte stream over a valid/ready interface and shifts it serially into the chain.
- Captures the bits displaced from the chain at the same time and returns them as a byte stream.
- Used to program the memory image and the IO registers, and to read back CPU state; busy stalls the CPU while a session runs.

Parameters:
- CHAIN_LEN, 256, total scan chain length in bits (31x8 memory + 1 button + 7 LED); must be a multiple of 8.
- NUM_BYTES, CHAIN_LEN/8, localparam: bytes per session.
- CNT_W, 6, localparam: byte counter width, clog2(NUM_BYTES)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a session; honoured only in IDLE.
- abort  in  1  terminates a session at the next edge.
- in_data  in  8  byte to shift into the chain.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- out_data  out  8  byte captured from scan_out.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host takes out_data this cycle.
- scan_enable  out  1  chain shift enable.
- scan_in  out  1  serial data into the chain.
- scan_out  in  1  serial data from the chain tail.
- busy  out  1  session in progress; gates the CPU.
- done  out  1  one-cycle pulse when a session completes normally.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; tx, rx, bit_cnt and byte_cnt cleared; all outputs 0.
- FSM states: IDLE, LOAD, SHIFT, EMIT, FIN.
- IDLE: start moves to LOAD and clears byte_cnt. in_valid is ignored.
- LOAD: in_ready=1. On in_valid&&in_ready: tx<=in_data, bit_cnt<=0, move to SHIFT.
- SHIFT: scan_enable=1, scan_in=tx[7] (MSB first).
  - Each edge: tx<=tx<<1, rx<={rx[6:0],scan_out}, bit_cnt++.
  - After the edge with bit_cnt==7, move to EMIT.
  - scan_enable is high for exactly 8 consecutive cycles per byte.
- EMIT: out_valid=1, out_data=rx, scan_enable=0 so the chain holds.
  - On out_ready: byte_cnt++.
  - If byte_cnt+1==NUM_BYTES, move to FIN; else move to LOAD.
  - out_data stays stable while out_valid && !out_ready.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- in_ready, out_valid, scan_enable and done are decoded from the state register only. They must not depend combinationally on in_valid or out_ready.
- Latency: byte accepted at edge N gives out_valid high from edge N+8.
- Chain is a FIFO: a full session returns the prior chain contents in order. Replaying that stream restores the chain exactly.
- abort: from any non-IDLE state, next state is IDLE. scan_enable drops at that edge and no done pulse is produced. A partially shifted chain is left as-is.
- abort has priority over start, in/out handshakes and the FSM transitions in the same cycle.
- start outside IDLE: ignored.
- rst asserted mid-shift: immediate return to IDLE; chain contents undefined to the host.

Decomposition:
- Shared package: FSM state encoding (3-bit enum) and the default CHAIN_LEN for the current memory map (31 memory bytes + 8 IO bits).
- No sub-module is required. The 8-bit tx/rx shifters are inline.

Test Plan:
- Reset: assert rst mid-SHIFT -> next sample shows scan_enable=0, in_ready=0, out_valid=0, busy=0, done=0.
- Session 1: chain reset to 0; start; feed bytes 0x00..0x1F with out_ready=1 -> 32 output bytes all 0x00; scan_enable high for exactly 256 cycles total; one done pulse; busy falls the cycle after done.
- Session 2: feed 32 x 0xFF -> outputs 0x00,0x01,...,0x1F in order; chain model then all ones.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT -> scan_enable stays 0, out_data stable, no bit lost; remaining bytes are still correct.
- Abort: assert abort when bit_cnt==3 -> IDLE next edge, scan_enable 0, no done; chain model shows exactly 4 shifted bits.
- Protocol: start while busy, and in_valid while IDLE -> no effect; in_ready stays 0 in IDLE; byte counter unchanged.

Source files
------------

// File: rtl/scan_chain_loader_pkg.sv
// scan_chain_loader_pkg: shared FSM encoding and default chain geometry for the scan loader
package scan_chain_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_EMIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam int MEM_BYTES     = 31;
    localparam int IO_BITS       = 8;
    localparam int DEF_CHAIN_LEN = MEM_BYTES * 8 + IO_BITS;

endpackage

// File: rtl/scan_chain_loader.sv
// scan_chain_loader: shifts a host byte stream MSB-first through the scan chain
// and returns the displaced bits as a byte stream.
module scan_chain_loader
    import scan_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       busy,
    output logic       done
);

    localparam int NUM_BYTES = CHAIN_LEN / 8;
    localparam int CNT_W     = $clog2(NUM_BYTES) + 1;

    state_t           r_state, w_next;
    logic [7:0]       r_tx, r_rx;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_byte_cnt;
    logic             w_last;

    assign w_last = (r_byte_cnt + CNT_W'(1)) == CNT_W'(NUM_BYTES);

    // abort overrides every other transition, including start in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_next = in_valid ? ST_SHIFT : ST_LOAD;
            ST_SHIFT: w_next = (r_bit_cnt == 3'd7) ? ST_EMIT : ST_SHIFT;
            ST_EMIT:  w_next = !out_ready ? ST_EMIT : (w_last ? ST_FIN : ST_LOAD);
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (abort)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (!abort) begin
                if (r_state == ST_IDLE && start)
                    r_byte_cnt <= '0;
                if (r_state == ST_LOAD && in_valid) begin
                    r_tx      <= in_data;
                    r_bit_cnt <= '0;
                end
                if (r_state == ST_SHIFT) begin
                    r_tx      <= {r_tx[6:0], 1'b0};
                    r_rx      <= {r_rx[6:0], scan_out};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (r_state == ST_EMIT && out_ready)
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready    = r_state == ST_LOAD;
    assign scan_enable = r_state == ST_SHIFT;
    assign scan_in     = scan_enable & r_tx[7];
    assign out_valid   = r_state == ST_EMIT;
    assign out_data    = r_rx;
    assign done        = r_state == ST_FIN;
    assign busy        = r_state != ST_IDLE;

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb_scan_chain_loader: drives sessions against a modelled 256-bit chain and
// checks returned bytes against a bit-FIFO reference of the chain contents.
module tb_scan_chain_loader;

    logic       clk = 1'b0;
    logic       rst, start, abort, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, scan_enable, scan_in, scan_out, busy, done;
    logic [7:0] out_data;

    logic [255:0] chain;
    logic [7:0]   din [32];
    bit           mq [$];
    int           n_chk, n_fail, se_cnt, done_cnt;

    scan_chain_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // the physical chain: head takes scan_in, tail drives scan_out
    assign scan_out = chain[255];
    always @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else if (scan_enable) chain <= {chain[254:0], scan_in};
    end

    always @(negedge clk) begin
        if (scan_enable === 1'b1) se_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic model_clear;
        mq.delete();
        for (int k = 0; k < 256; k++) mq.push_back(1'b0);
    endtask

    task automatic check_chain(input string tag);
        int bad = 0;
        for (int k = 0; k < 256; k++)
            if (chain[255-k] !== mq[k]) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s chain: %0d bits differ from model, want 0", tag, bad);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_chk++;
        if ({scan_enable, in_ready, out_valid, busy, done, scan_in} !== 6'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL %s outputs: se=%b ir=%b ov=%b busy=%b done=%b si=%b od=%h, want all 0",
                     tag, scan_enable, in_ready, out_valid, busy, done, scan_in, out_data);
        end
    endtask

    task automatic do_session(input int bp, input bit noise, input string tag);
        int lat, to, se0, dn0;
        logic [7:0] exp, d0;
        se0 = se_cnt;
        dn0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            to = 0;
            do begin @(negedge clk); to++; end while (in_ready !== 1'b1 && to < 20);
            n_chk++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s in_ready byte %0d: got %b want 1", tag, i, in_ready);
                return;
            end
            in_data = din[i]; in_valid = 1'b1; out_ready = (i != bp); start = noise;
            @(posedge clk); #1 in_valid = 1'b0; start = 1'b0; in_data = 8'($urandom);
            exp = '0;
            for (int b = 7; b >= 0; b--) begin
                exp = {exp[6:0], mq.pop_front()};
                mq.push_back(din[i][b]);
            end
            for (lat = 0; lat < 20; lat++) begin
                @(negedge clk);
                if (out_valid === 1'b1) break;
            end
            n_chk++;
            if (lat != 8) begin
                n_fail++;
                $display("FAIL %s latency byte %0d: got %0d want 8", tag, i, lat);
                if (lat >= 20) return;
            end
            n_chk++;
            if (out_data !== exp) begin
                n_fail++;
                $display("FAIL %s data byte %0d: got %h want %h", tag, i, out_data, exp);
            end
            if (i == bp) begin
                d0 = out_data;
                repeat (5) begin
                    @(negedge clk);
                    n_chk++;
                    if (scan_enable !== 1'b0 || out_valid !== 1'b1 || out_data !== d0) begin
                        n_fail++;
                        $display("FAIL %s stall: se=%b ov=%b od=%h want se=0 ov=1 od=%h",
                                 tag, scan_enable, out_valid, out_data, d0);
                    end
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done pulse: done=%b busy=%b want 1 1", tag, done, busy);
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after done: done=%b busy=%b want 0 0", tag, done, busy);
        end
        n_chk++;
        if (se_cnt - se0 != 256 || done_cnt - dn0 != 1) begin
            n_fail++;
            $display("FAIL %s counts: scan_enable cycles=%0d done pulses=%0d want 256 1",
                     tag, se_cnt - se0, done_cnt - dn0);
        end
        check_chain(tag);
    endtask

    task automatic test_reset;
        #5 check_idle_outputs("reset_hold");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (scan_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preshift scan_enable: got %b want 1", scan_enable);
        end
        #1 rst = 1'b1;
        #1 check_idle_outputs("reset_async");
        @(negedge clk) check_idle_outputs("reset_sample");
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        check_chain("reset");
    endtask

    task automatic test_session1;
        for (int i = 0; i < 32; i++) din[i] = 8'(i);
        do_session(-1, 1'b0, "session1");
    endtask

    task automatic test_session2;
        for (int i = 0; i < 32; i++) din[i] = 8'hFF;
        do_session(-1, 1'b0, "session2");
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 32; i++) din[i] = 8'($urandom);
        do_session($urandom_range(0, 31), 1'b0, "backpressure");
    endtask

    task automatic test_abort;
        int se0, dn0;
        logic [7:0] d;
        se0 = se_cnt;
        dn0 = done_cnt;
        d = 8'($urandom);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_data = d; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        for (int b = 7; b >= 4; b--) begin
            void'(mq.pop_front());
            mq.push_back(d[b]);
        end
        @(negedge clk);
        n_chk++;
        if (scan_enable !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort state: se=%b busy=%b ir=%b ov=%b want all 0",
                     scan_enable, busy, in_ready, out_valid);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (se_cnt - se0 != 4 || done_cnt != dn0) begin
            n_fail++;
            $display("FAIL abort counts: shifts=%0d done pulses=%0d want 4 0",
                     se_cnt - se0, done_cnt - dn0);
        end
        check_chain("abort");
    endtask

    task automatic test_protocol;
        int se0;
        se0 = se_cnt;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1 in_valid = 1'b1; in_data = 8'($urandom);
            @(negedge clk);
            n_chk++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || scan_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_in_valid cycle %0d: ir=%b busy=%b se=%b want 0 0 0",
                         c, in_ready, busy, scan_enable);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        n_chk++;
        if (se_cnt != se0) begin
            n_fail++;
            $display("FAIL idle_shift: got %0d shifts want 0", se_cnt - se0);
        end
        check_chain("idle_chain");
        for (int i = 0; i < 32; i++) din[i] = 8'($urandom);
        do_session(-1, 1'b1, "start_while_busy");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        n_chk = 0; n_fail = 0; se_cnt = 0; done_cnt = 0;
        #2 rst = 1'b1;
        test_reset();
        test_session1();
        test_session2();
        test_backpressure();
        test_abort();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
